// File: rtl/move_scheduler_if.sv
// Handshake and byte-stream bundle between ps2_rx, the move scheduler and game logic.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface move_scheduler_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       frame_tick;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] move;
    logic [4:0] held_keys;

    modport slave (
        input  rx_done_tick,
        input  rx_data,
        input  frame_tick,
        input  move_ready,
        output move_valid,
        output move,
        output held_keys
    );

    modport master (
        output rx_done_tick,
        output rx_data,
        output frame_tick,
        output move_ready,
        input  move_valid,
        input  move,
        input  held_keys
    );
endinterface

// File: rtl/move_scheduler.sv
// PS/2 set-2 decoder into a five-key held bitmap plus a per-frame rotating-priority move issuer.
// Optional MOVE_SCHED_OVERRUN_EN adds overrun_count, tallying frame ticks dropped while keys are held.
module move_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 17
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    move_scheduler_if.slave   sched_if
`ifdef MOVE_SCHED_OVERRUN_EN
    ,
    output logic [7:0]        overrun_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t          state_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [4:0]      held_keys_q;
    logic [2:0]      ptr_q;
    logic [2:0]      ptr_d;
    logic            move_valid_q;
    logic            move_valid_d;
    logic [2:0]      move_q;
    logic [2:0]      move_d;
    logic [9:0]      rot_s;
    logic            grant_found_s;
    logic [2:0]      grant_off_s;
    logic [2:0]      grant_idx_s;
    logic            slot_free_s;

    // Extended (E0-prefixed) scan code to held-bitmap mask; zero for keys we do not track.
    function automatic logic [4:0] ext_key_mask(input logic [7:0] code);
        logic [4:0] mask;
        case (code)
            8'h75:   mask = 5'b00001;
            8'h72:   mask = 5'b00010;
            8'h6B:   mask = 5'b00100;
            8'h74:   mask = 5'b01000;
            default: mask = 5'b00000;
        endcase
        return mask;
    endfunction

    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    // Scan-code decoder FSM with prefix timeout; owns the held-key bitmap.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            to_cnt_q    <= '0;
            held_keys_q <= 5'b00000;
        end else if (sched_if.rx_done_tick) begin
            to_cnt_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sched_if.rx_data == 8'hE0) begin
                        state_q <= ST_EXT;
                    end else if (sched_if.rx_data == 8'hF0) begin
                        state_q <= ST_BRK;
                    end else begin
                        if (sched_if.rx_data == 8'h29) begin
                            held_keys_q[4] <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (sched_if.rx_data == 8'hF0) begin
                        state_q <= ST_EXT_BRK;
                    end else begin
                        held_keys_q <= held_keys_q | ext_key_mask(sched_if.rx_data);
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (sched_if.rx_data == 8'h29) begin
                        held_keys_q[4] <= 1'b0;
                    end
                    state_q <= ST_IDLE;
                end
                ST_EXT_BRK: begin
                    held_keys_q <= held_keys_q & ~ext_key_mask(sched_if.rx_data);
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // Fires on the TIMEOUT_CYCLES-th idle edge after the prefix was sampled.
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_q  <= ST_IDLE;
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign slot_free_s = !move_valid_q || sched_if.move_ready;

    // Rotating-priority pick: rotate the bitmap so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_s         = {held_keys_q, held_keys_q} >> ptr_q;
        grant_found_s = 1'b0;
        grant_off_s   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (!grant_found_s && rot_s[k]) begin
                grant_found_s = 1'b1;
                grant_off_s   = 3'(k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_idx_s = wrap_idx(ptr_q, grant_off_s);
    end

    // Next-state for the output slot: grant beats release; a pure transfer empties the slot.
    always_comb begin
        move_d       = move_q;
        move_valid_d = move_valid_q;
        ptr_d        = ptr_q;
        if (sched_if.frame_tick && slot_free_s && grant_found_s) begin
            move_d       = grant_idx_s + 3'd1;
            move_valid_d = 1'b1;
            ptr_d        = wrap_idx(grant_idx_s, 3'd1);
        end else if (move_valid_q && sched_if.move_ready) begin
            move_d       = 3'b000;
            move_valid_d = 1'b0;
        end else begin
            move_d       = move_q;
        end
    end

    // Output slot and arbitration pointer registers.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            move_q       <= 3'b000;
            move_valid_q <= 1'b0;
            ptr_q        <= 3'd0;
        end else begin
            move_q       <= move_d;
            move_valid_q <= move_valid_d;
            ptr_q        <= ptr_d;
        end
    end

    assign sched_if.move_valid = move_valid_q;
    assign sched_if.move       = move_q;
    assign sched_if.held_keys  = held_keys_q;

`ifdef MOVE_SCHED_OVERRUN_EN
    logic [7:0] overrun_q;

    // Saturating count of frame ticks lost to an occupied slot while keys are held.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            overrun_q <= 8'd0;
        end else if (sched_if.frame_tick && !slot_free_s && (held_keys_q != 5'b00000)
                     && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    assign overrun_count = overrun_q;
`endif

endmodule
